spike_aer_encoder: RTL and testbench
====================================

# spike_aer_encoder

Downstream consumer of the 8-neuron time-multiplexed LIF array. Each time the array presents a spike vector, this block captures it and serialises every set bit into an address-event (AER) word `{timestep, neuron address}`. Events are buffered in a small FIFO and handed to the output bus over a valid/ready handshake. Overload is reported by a sticky overflow flag and a saturating drop counter.

## Interface
Parameters:
- `N_NEURONS`, 8: spike vector width; power of 2.
- `AW`, $clog2(N_NEURONS) = 3: neuron address width.
- `TS_W`, 8: timestep counter width.
- `DEPTH`, 8: event FIFO depth; power of 2, ≥2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `spike_valid` in 1: strobe marking one neuron timestep; `spike` is sampled when it is high.
- `spike` in N_NEURONS: spike vector; bit i is neuron i.
- `aer_ready` in 1: downstream accepts the head event.
- `aer_valid` out 1: head event valid.
- `aer_addr` out AW: neuron index of the head event.
- `aer_ts` out TS_W: timestep of the head event.
- `busy` out 1: pending spike register non-empty.
- `overflow` out 1: sticky; set when a spike vector was dropped.
- `drop_cnt` out 8: saturating count of dropped spikes (set bits), caps at 255.
- `clr_ovf` in 1: clears `overflow` and `drop_cnt`.

## Operation
- State:
  - `pending[N_NEURONS]`
  - `ts_cnt[TS_W]`
  - `ts_hold[TS_W]`: timestep of the vector held in `pending`
  - event FIFO
  - `overflow`, `drop_cnt`
- Acceptance: a vector with `spike_valid=1` is accepted when `pending` will be empty after this edge. That is true if `pending==0`, or if `pending` has exactly one bit set and that bit is pushed this cycle.
  - On accept: `pending<=spike`, `ts_hold<=ts_cnt`.
  - An all-zero vector is accepted and produces no events.
- Drop: `spike_valid=1` but not accepted. The vector is discarded, `pending` is unchanged, `overflow<=1`, and `drop_cnt<=min(255, drop_cnt+popcount(spike))`.
- Timestep: `ts_cnt` increments on every `spike_valid`, whether the vector is accepted or dropped. It wraps from 2^TS_W−1 to 0.
- Scanner: each cycle with `pending!=0` and FIFO push allowed, the lowest set index k is chosen. The block pushes `{ts_hold,k}` and clears `pending[k]`. Events leave in ascending address order within a timestep.
- FIFO:
  - Push is allowed when the FIFO is not full, or when it is full and `aer_valid&&aer_ready` (simultaneous pop).
  - When the FIFO is full with no pop, the scanner stalls; nothing is lost.
  - Pop occurs on `aer_valid&&aer_ready`.
  - `aer_valid` = FIFO non-empty. The head is read from the storage array.
  - There is no fall-through path.
- `clr_ovf` and a drop in the same cycle: the drop wins. `overflow=1` and `drop_cnt=popcount(spike)`, starting from 0.
- Reset (`rst=1` at an edge), including mid-operation:
  - `pending=0`, FIFO empty, `ts_cnt=0`.
  - `aer_valid=0`, `busy=0`, `overflow=0`, `drop_cnt=0`.
  - `aer_addr` and `aer_ts` read 0.
  - All inputs are ignored that cycle; in-flight events are discarded.

## Timing
- `spike_valid` sampled at edge N → `pending` loaded at N. The first event is pushed at N+1, and `aer_valid` is high after N+1, i.e. 2-cycle latency.
- Throughput is 1 event per cycle with `aer_ready` held high. A vector with m set bits needs m cycles to drain.
- Back-to-back `spike_valid` is accepted only if the previous vector had ≤1 set bit. Otherwise the new vector is dropped.
- `aer_addr` and `aer_ts` must stay stable while `aer_valid && !aer_ready`.
- `busy` is combinational from `pending!=0`.

## Structure
- Shared package `lif_pkg`:
  - `N_NEURONS`, `AW`, `TS_W`
  - `aer_event_t` packed struct `{ts[TS_W], addr[AW]}`, shared with the LIF array and the AER sink.
- One sub-module, `aer_fifo`:
  - parameters: width, `DEPTH`
  - ports: push/pop, full/empty
  - pointers with an extra wrap bit; no almost-full.
- The priority encoder and popcount live inline in the top module.

## Test plan
- Reset, then `spike=8'b1010_0100` at ts 0, `aer_ready=1` → events (0,2),(0,5),(0,7) on 3 consecutive cycles. The first appears 2 cycles after the strobe.
- `spike=8'hFF` with `aer_ready=0` → FIFO fills with 8 events and `busy=0`. Raising `aer_ready` yields addr 0..7 in order; nothing is dropped.
- `8'h03` then `8'hF0` on consecutive cycles → second vector dropped, `overflow=1`, `drop_cnt=4`, and only (0,0),(0,1) are emitted. The next valid vector carries ts 2.
- `8'h01` then `8'h02` back-to-back → both accepted; events (0,0),(1,1).
- 256 strobes of `8'h00`, then `8'h80` → event (0,7), confirming ts wrap. `clr_ovf` asserted together with a dropping strobe of popcount 3 → `drop_cnt=3`, `overflow=1`.
- `rst` asserted while `pending` and the FIFO are non-empty → next cycle `aer_valid=0`, `busy=0`, counters 0. Post-reset traffic starts at ts 0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron array and its AER event path.
package lif_pkg;

  localparam int unsigned N_NEURONS = 8;
  localparam int unsigned AW        = $clog2(N_NEURONS);
  localparam int unsigned TS_W      = 8;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [AW-1:0]   addr;
  } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// Event FIFO with wrap-bit pointers; the head is read straight from storage.
module aer_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures spike vectors from the LIF array and serialises set bits into
// {timestep, address} events through a small FIFO with valid/ready output.
module spike_aer_encoder #(
  parameter int unsigned N_NEURONS = lif_pkg::N_NEURONS,
  parameter int unsigned AW        = $clog2(N_NEURONS),
  parameter int unsigned TS_W      = lif_pkg::TS_W,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spike_valid,
  input  logic [N_NEURONS-1:0] spike,
  input  logic                 aer_ready,
  output logic                 aer_valid,
  output logic [AW-1:0]        aer_addr,
  output logic [TS_W-1:0]      aer_ts,
  output logic                 busy,
  output logic                 overflow,
  output logic [7:0]           drop_cnt,
  input  logic                 clr_ovf
);

  localparam int unsigned EW = TS_W + AW;

  logic [N_NEURONS-1:0] pending_q, pending_d, pending_after;
  logic [TS_W-1:0]      ts_cnt_q, ts_hold_q;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic [AW-1:0] k;
  logic          push, pop, push_ok, accept, drop;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_head;
  int unsigned   popcnt, drop_sum;

  // Lowest set index wins so events leave in ascending address order.
  always_comb begin
    k = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) k = AW'(i);
    end
  end

  always_comb begin
    popcnt = 0;
    for (int i = 0; i < N_NEURONS; i++) popcnt = popcnt + 32'(spike[i]);
  end

  assign pop     = aer_valid && aer_ready;
  assign push_ok = !fifo_full || pop;
  assign push    = (pending_q != '0) && push_ok;

  // A new vector fits if pending will be empty after this edge.
  always_comb begin
    pending_after = pending_q;
    if (push) pending_after[k] = 1'b0;
  end

  assign accept = spike_valid && (pending_after == '0);
  assign drop   = spike_valid && !accept;

  always_comb begin
    pending_d  = accept ? spike : pending_after;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = 0;
    if (drop) begin
      // A drop overrides a simultaneous clear: count restarts from zero.
      drop_sum   = (clr_ovf ? 0 : 32'(drop_cnt_q)) + popcnt;
      overflow_d = 1'b1;
      drop_cnt_d = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      ts_cnt_q   <= '0;
      ts_hold_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      if (spike_valid) ts_cnt_q  <= ts_cnt_q + TS_W'(1);
      if (accept)      ts_hold_q <= ts_cnt_q;
    end
  end

  aer_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ts_hold_q, k}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign aer_valid = !fifo_empty;
  assign aer_addr  = fifo_empty ? '0 : fifo_head[AW-1:0];
  assign aer_ts    = fifo_empty ? '0 : fifo_head[EW-1:AW];
  assign busy      = (pending_q != '0);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: expected events queued at each strobe.
module tb_spike_aer_encoder;
  import lif_pkg::*;

  logic       clk = 1'b0;
  logic       rst, spike_valid, aer_ready, clr_ovf;
  logic [7:0] spike;
  logic       aer_valid, busy, overflow;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts, drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  tb_ts;
  aer_event_t  exp_q[$];

  spike_aer_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .spike_valid (spike_valid),
    .spike       (spike),
    .aer_ready   (aer_ready),
    .aer_valid   (aer_valid),
    .aer_addr    (aer_addr),
    .aer_ts      (aer_ts),
    .busy        (busy),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe; the bench decides whether the vector should be accepted.
  task automatic strobe(input logic [7:0] v, input bit acc);
    aer_event_t e;
    spike_valid = 1'b1;
    spike       = v;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          e.ts   = tb_ts;
          e.addr = 3'(i);
          exp_q.push_back(e);
        end
      end
    end
    tb_ts = tb_ts + 8'd1;
    tick();
    spike_valid = 1'b0;
    spike       = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300 && (exp_q.size() != 0 || aer_valid || busy)) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", aer_valid, 0);
  endtask

  // Handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    aer_event_t e;
    if (!rst && aer_valid && aer_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {aer_ts, 5'(aer_addr)}, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_addr", aer_addr, e.addr);
        check("ev_ts", aer_ts, e.ts);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; spike_valid = 1'b0; spike = '0; aer_ready = 1'b1; clr_ovf = 1'b0;
    tb_ts = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", aer_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_addr", aer_addr, 0);
    check("rst_ts", aer_ts, 0);

    // Latency: strobe at edge N, aer_valid after N+1.
    strobe(8'b1010_0100, 1'b1);
    check("lat_n_valid", aer_valid, 0);
    check("lat_n_busy", busy, 1);
    tick();
    check("lat_n1_valid", aer_valid, 1);
    check("lat_n1_addr", aer_addr, 2);
    wait_idle();

    // Fill FIFO while stalled; head must hold.
    aer_ready = 1'b0;
    strobe(8'hFF, 1'b1);
    repeat (8) tick();
    check("full_busy", busy, 0);
    check("full_valid", aer_valid, 1);
    check("full_head", aer_addr, 0);
    tick();
    check("stall_head", aer_addr, 0);
    aer_ready = 1'b1;
    wait_idle();
    check("full_no_ovf", overflow, 0);

    // Second vector dropped while two-bit vector still pending.
    strobe(8'h03, 1'b1);
    strobe(8'hF0, 1'b0);
    check("drop_ovf", overflow, 1);
    check("drop_cnt4", drop_cnt, 4);
    wait_idle();
    strobe(8'h10, 1'b1);
    wait_idle();

    // Single-bit vectors can go back-to-back.
    strobe(8'h01, 1'b1);
    strobe(8'h02, 1'b1);
    check("b2b_ovf_kept", drop_cnt, 4);
    wait_idle();

    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_cnt, 0);

    // Timestep wrap.
    do strobe(8'h00, 1'b1); while (tb_ts != 8'd0);
    strobe(8'h80, 1'b1);
    wait_idle();

    // Saturation: FIFO full, pending stuck, then 32 full drops.
    aer_ready = 1'b0;
    strobe(8'hFF, 1'b1);
    repeat (8) tick();
    strobe(8'hFF, 1'b1);
    tick();
    check("stuck_busy", busy, 1);
    for (int i = 0; i < 32; i++) strobe(8'hFF, 1'b0);
    check("sat_drop", drop_cnt, 255);
    clr_ovf = 1'b1;
    strobe(8'h07, 1'b0);
    clr_ovf = 1'b0;
    check("clr_vs_drop_cnt", drop_cnt, 3);
    check("clr_vs_drop_ovf", overflow, 1);
    aer_ready = 1'b1;
    wait_idle();

    // Reset mid-operation.
    aer_ready = 1'b0;
    strobe(8'hFF, 1'b1);
    repeat (3) tick();
    strobe(8'h01, 1'b0);
    check("pre_rst_valid", aer_valid, 1);
    rst = 1'b1;
    spike_valid = 1'b1; spike = 8'hFF;
    tick();
    rst = 1'b0; spike_valid = 1'b0; spike = '0;
    exp_q.delete();
    tb_ts = '0;
    check("mid_rst_valid", aer_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_addr", aer_addr, 0);
    check("mid_rst_ts", aer_ts, 0);
    aer_ready = 1'b1;
    strobe(8'h40, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
